ray_tri_scheduler: RTL and testbench

RAY_TRI_SCHEDULER -- requirements
Module: ray_tri_scheduler

---
 rtl/ray_tri_scheduler.sv | 151 +++++++++++++++
 tb/tb_ray_tri_scheduler.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_tri_scheduler.sv
// Feeds triangles to a pipelined ray/triangle intersection unit and keeps the closest hit.
// Optional build macro SCHED_ANYHIT_EN: stop issuing at the first reported hit.
module ray_tri_scheduler #(
  parameter int IDX_W        = 16,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic signed [0:1][0:2][31:0]   i_ray,
  input  logic        [IDX_W-1:0]        i_num_tri,
  input  logic                           i_tri_valid,
  input  logic signed [0:2][0:2][31:0]   i_tri,
  output logic                           o_tri_ready,
  output logic                           o_isect_en,
  output logic        [0:2][0:2][31:0]   o_isect_tri,
  output logic        [0:1][0:2][31:0]   o_isect_ray,
  input  logic signed [31:0]             i_isect_t,
  input  logic                           i_isect_result,
  input  logic                           i_isect_valid,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_hit,
  output logic signed [31:0]             o_hit_t,
  output logic        [IDX_W-1:0]        o_hit_idx,
  output logic                           o_err
);

  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int CW = PW + 1;
  localparam logic signed [31:0] T_MAX = 32'sh7FFF_FFFF;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state;
  state_t state_n;

  logic [0:1][0:2][31:0] ray_q;
  logic [IDX_W-1:0]      num_q;
  logic [IDX_W-1:0]      issued;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         inflight_n;
  logic [IDX_W-1:0]      tags [MAX_INFLIGHT];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic signed [31:0]    best_t;

  logic start_ok;
  logic push;
  logic pop;
  logic stop;
  logic take;
  logic ready;
  logic done_set;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    start_ok = 1'b0;
    pop      = i_isect_valid && (inflight != '0);
`ifdef SCHED_ANYHIT_EN
    // the first hit wins; later hits are popped but never recorded
    stop     = pop && i_isect_result;
    take     = stop && !o_hit;
`else
    stop     = 1'b0;
    take     = pop && i_isect_result && (i_isect_t < best_t);
`endif
    ready    = (state == RUN)
            && (issued < num_q)
            && (inflight < CW'(MAX_INFLIGHT))
            && !stop;
    push       = ready && i_tri_valid;
    inflight_n = inflight + CW'(push) - CW'(pop);
    unique case (state)
      IDLE, DONE: begin
        if (i_start) begin
          start_ok = 1'b1;
          state_n  = (i_num_tri == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ((issued == num_q) || stop) state_n = DRAIN;
      end
      DRAIN: begin
        if (inflight_n == '0) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    done_set = (state_n == DONE) && ((state != DONE) || start_ok);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ray_q       <= '0;
      num_q       <= '0;
      issued      <= '0;
      inflight    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      best_t      <= T_MAX;
      o_hit       <= 1'b0;
      o_hit_idx   <= '0;
      o_err       <= 1'b0;
      o_done      <= 1'b0;
      o_isect_en  <= 1'b0;
      o_isect_tri <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) tags[i] <= '0;
    end else begin
      o_isect_en <= push;
      o_done     <= done_set;
      inflight   <= inflight_n;
      if (push) begin
        o_isect_tri  <= i_tri;
        tags[wr_ptr] <= issued;
        wr_ptr       <= wr_ptr + 1'b1;
        issued       <= issued + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (start_ok) begin
        ray_q     <= i_ray;
        num_q     <= i_num_tri;
        issued    <= '0;
        best_t    <= T_MAX;
        o_hit     <= 1'b0;
        o_hit_idx <= '0;
        o_err     <= 1'b0;
      end else begin
        if (take) begin
          best_t    <= i_isect_t;
          o_hit_idx <= tags[rd_ptr];
          o_hit     <= 1'b1;
        end
        // a result nobody asked for is only an error while a job is live
        if (i_isect_valid && (inflight == '0)
            && ((state == RUN) || (state == DRAIN)))
          o_err <= 1'b1;
      end
    end
  end

  assign o_tri_ready = ready;
  assign o_isect_ray = ray_q;
  assign o_busy      = (state == RUN) || (state == DRAIN);
  assign o_hit_t     = best_t;

endmodule

// File: tb/tb_ray_tri_scheduler.sv
// Scoreboard bench for ray_tri_scheduler: issued triangles, result timing,
// closest/any hit selection, backpressure, reset abandonment.
module tb_ray_tri_scheduler;

  localparam int IDX_W = 16;
  localparam int MAXI  = 8;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         start = 1'b0;
  logic signed [0:1][0:2][31:0] ray = '0;
  logic        [IDX_W-1:0]      num_tri = '0;
  logic                         tri_valid = 1'b0;
  logic signed [0:2][0:2][31:0] tri_d = '0;
  logic                         tri_ready;
  logic                         isect_en;
  logic        [0:2][0:2][31:0] isect_tri;
  logic        [0:1][0:2][31:0] isect_ray;
  logic signed [31:0]           isect_t = '0;
  logic                         isect_result = 1'b0;
  logic                         isect_valid = 1'b0;
  logic                         busy;
  logic                         done;
  logic                         hit;
  logic signed [31:0]           hit_t;
  logic        [IDX_W-1:0]      hit_idx;
  logic                         err;

  ray_tri_scheduler #(.IDX_W(IDX_W), .MAX_INFLIGHT(MAXI)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_ray(ray),
    .i_num_tri(num_tri), .i_tri_valid(tri_valid), .i_tri(tri_d),
    .o_tri_ready(tri_ready), .o_isect_en(isect_en),
    .o_isect_tri(isect_tri), .o_isect_ray(isect_ray),
    .i_isect_t(isect_t), .i_isect_result(isect_result),
    .i_isect_valid(isect_valid), .o_busy(busy), .o_done(done),
    .o_hit(hit), .o_hit_t(hit_t), .o_hit_idx(hit_idx), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int idx;} resp_t;
  typedef logic [0:2][0:2][31:0] tri_t;

  resp_t rq[$];
  tri_t  exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int model_infl = 0;
  int max_infl = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int en_idx = 0;
  int resp_delay = 3;
  bit prev_acc = 0;
  bit rst_edge = 0;
  bit ready_seen = 0;
  bit hit_popped = 0;
  bit ready_after_hit = 0;
  bit feed_en = 0;
  bit feed_const = 0;
  logic [0:1][0:2][31:0] ray_exp = '0;
  logic                  res_hit [64];
  logic signed [31:0]    res_t   [64];

  // stimulus driver: triangle stream and delayed intersection results
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tri_valid = feed_en && (feed_const || ($urandom_range(0, 2) != 0));
      for (int a = 0; a < 3; a++)
        for (int b = 0; b < 3; b++) tri_d[a][b] = $urandom;
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        isect_valid  = 1'b1;
        isect_result = res_hit[rq[0].idx];
        isect_t      = res_t[rq[0].idx];
        void'(rq.pop_front());
      end else begin
        isect_valid  = 1'b0;
        isect_result = 1'b0;
        isect_t      = '0;
      end
    end
  end

  always @(posedge clk) rst_edge <= rst;

  // monitor: issue timing, triangle scoreboard, inflight limit
  always @(negedge clk) begin
    if (rst_edge) begin
      n_cmp++;
      if (isect_en !== 1'b0) begin
        n_bad++;
        $display("FAIL isect_en_reset got=%b want=0", isect_en);
      end
      model_infl = 0;
      prev_acc   = 0;
      en_idx     = 0;
      exp_q.delete();
    end else begin
      n_cmp++;
      if (isect_en !== prev_acc) begin
        n_bad++;
        $display("FAIL isect_en_timing t=%0t got=%b want=%b",
                 $time, isect_en, prev_acc);
      end
      if (isect_en === 1'b1) begin
        en_cnt++;
        if (exp_q.size() > 0) begin
          tri_t e;
          e = exp_q.pop_front();
          n_cmp++;
          if (isect_tri !== e) begin
            n_bad++;
            $display("FAIL isect_tri got=%h want=%h", isect_tri, e);
          end
        end
        n_cmp++;
        if (isect_ray !== ray_exp) begin
          n_bad++;
          $display("FAIL isect_ray got=%h want=%h", isect_ray, ray_exp);
        end
        rq.push_back('{cyc + resp_delay, en_idx});
        en_idx++;
      end
    end
    if (start === 1'b1) en_idx = 0;
    if (tri_ready === 1'b1) begin
      ready_seen = 1;
      if (hit_popped) ready_after_hit = 1;
      n_cmp++;
      if (model_infl >= MAXI) begin
        n_bad++;
        $display("FAIL ready_over_limit inflight=%0d limit=%0d",
                 model_infl, MAXI);
      end
    end
    if (isect_valid === 1'b1 && model_infl > 0) begin
      model_infl--;
      if (isect_result === 1'b1) hit_popped = 1;
    end
    prev_acc = (tri_valid === 1'b1) && (tri_ready === 1'b1);
    if (prev_acc) begin
      exp_q.push_back(tri_d);
      model_infl++;
    end
    if (model_infl > max_infl) max_infl = model_infl;
    if (done === 1'b1) done_cnt++;
  end

  function automatic logic signed [0:1][0:2][31:0] make_ray();
    logic signed [0:1][0:2][31:0] r;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 3; b++) r[a][b] = $urandom;
    return r;
  endfunction

  function automatic void clear_tables();
    for (int i = 0; i < 64; i++) begin
      res_hit[i] = 1'b0;
      res_t[i]   = '0;
    end
  endfunction

  // reference selection over the result table in issue order
  function automatic void model(input int n, output bit mh,
                                output logic signed [31:0] mt,
                                output int mi);
    mh = 0;
    mt = 32'sh7FFF_FFFF;
    mi = 0;
    for (int i = 0; i < n; i++) begin
      if (res_hit[i]) begin
`ifdef SCHED_ANYHIT_EN
        if (!mh) begin
          mh = 1; mt = res_t[i]; mi = i;
        end
`else
        if (res_t[i] < mt) begin
          mh = 1; mt = res_t[i]; mi = i;
        end
`endif
      end
    end
  endfunction

  task automatic start_job(input int n);
    @(posedge clk);
    #1;
    ray             = make_ray();
    ray_exp         = ray;
    num_tri         = IDX_W'(n);
    start           = 1'b1;
    hit_popped      = 0;
    ready_after_hit = 0;
    ready_seen      = 0;
    en_cnt          = 0;
    max_infl        = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int base;
    base = done_cnt;
    ok   = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt > base) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    n_cmp += 7;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b want=0", done); end
    if (hit !== 1'b0) begin n_bad++; $display("FAIL rst_hit got=%b want=0", hit); end
    if (hit_t !== 32'sh7FFF_FFFF) begin n_bad++; $display("FAIL rst_hit_t got=%h want=7fffffff", hit_t); end
    if (hit_idx !== '0) begin n_bad++; $display("FAIL rst_hit_idx got=%0d want=0", hit_idx); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b want=0", err); end
    if (tri_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b want=0", tri_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #2;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_closest();
    bit ok, mh;
    logic signed [31:0] mt;
    int mi;
    clear_tables();
    res_hit[0] = 1'b1; res_t[0] = 32'sh0003_0000;
    res_hit[1] = 1'b1; res_t[1] = 32'sh0001_0000;
    res_hit[2] = 1'b0; res_t[2] = 32'sh0000_0000;
    resp_delay = 3;
    feed_const = 0;
    feed_en    = 1;
    start_job(3);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL closest_busy got=%b want=1", busy); end
    wait_done(200, ok);
    feed_en = 0;
    model(3, mh, mt, mi);
    n_cmp += 6;
    if (!ok) begin n_bad++; $display("FAIL closest_done_timeout got=0 want=1"); end
    if (hit !== mh) begin n_bad++; $display("FAIL closest_hit got=%b want=%b", hit, mh); end
    if (hit_t !== mt) begin n_bad++; $display("FAIL closest_t got=%h want=%h", hit_t, mt); end
    if (hit_idx !== IDX_W'(mi)) begin n_bad++; $display("FAIL closest_idx got=%0d want=%0d", hit_idx, mi); end
    if (en_cnt != 3) begin n_bad++; $display("FAIL closest_issued got=%0d want=3", en_cnt); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL closest_busy_done got=%b want=0", busy); end
    @(negedge clk);
    #2;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL closest_done_pulse got=%b want=0", done); end
    repeat (4) @(negedge clk);
    #2;
    n_cmp += 2;
    if (hit_t !== 32'sh0001_0000) begin n_bad++; $display("FAIL closest_hold_t got=%h want=00010000", hit_t); end
    if (hit_idx !== IDX_W'(1)) begin n_bad++; $display("FAIL closest_hold_idx got=%0d want=1", hit_idx); end
  endtask

  task automatic test_zero();
    feed_const = 1;
    feed_en    = 1;
    start_job(0);
    @(negedge clk);
    #2;
    n_cmp += 3;
    if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done got=%b want=1", done); end
    if (hit !== 1'b0) begin n_bad++; $display("FAIL zero_hit got=%b want=0", hit); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy got=%b want=0", busy); end
    @(negedge clk);
    #2;
    n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse got=%b want=0", done); end
    repeat (5) @(negedge clk);
    feed_en = 0;
    n_cmp += 2;
    if (ready_seen) begin n_bad++; $display("FAIL zero_ready got=1 want=0"); end
    if (en_cnt != 0) begin n_bad++; $display("FAIL zero_issued got=%0d want=0", en_cnt); end
  endtask

  task automatic test_err();
    bit ok;
    clear_tables();
    resp_delay = 2;
    feed_en    = 0;
    start_job(3);
    rq.push_back('{cyc, 0});
    repeat (3) @(negedge clk);
    #2;
    n_cmp += 2;
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b want=1", err); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL err_busy got=%b want=1", busy); end
    feed_const = 0;
    feed_en    = 1;
    wait_done(200, ok);
    feed_en = 0;
    n_cmp += 3;
    if (!ok) begin n_bad++; $display("FAIL err_done_timeout got=0 want=1"); end
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b want=1", err); end
    if (hit !== 1'b0) begin n_bad++; $display("FAIL err_hit got=%b want=0", hit); end
  endtask

  task automatic test_back_to_back();
    bit ok, mh;
    logic signed [31:0] mt;
    int mi;
    clear_tables();
    for (int i = 0; i < 20; i++) begin
      res_hit[i] = ($urandom_range(0, 2) == 0);
      res_t[i]   = 32'($urandom_range(1000, 900000));
    end
    res_hit[5] = 1'b1;
    resp_delay = 12;
    feed_const = 1;
    feed_en    = 1;
    start_job(20);
    wait_done(400, ok);
    feed_en = 0;
    model(20, mh, mt, mi);
    n_cmp += 7;
    if (!ok) begin n_bad++; $display("FAIL bp_done_timeout got=0 want=1"); end
    if (max_infl != MAXI) begin n_bad++; $display("FAIL bp_max_inflight got=%0d want=%0d", max_infl, MAXI); end
    if (en_cnt != 20) begin n_bad++; $display("FAIL bp_issued got=%0d want=20", en_cnt); end
    if (hit !== mh) begin n_bad++; $display("FAIL bp_hit got=%b want=%b", hit, mh); end
    if (hit_t !== mt) begin n_bad++; $display("FAIL bp_t got=%h want=%h", hit_t, mt); end
    if (hit_idx !== IDX_W'(mi)) begin n_bad++; $display("FAIL bp_idx got=%0d want=%0d", hit_idx, mi); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL bp_err got=%b want=0", err); end
  endtask

  task automatic test_tie();
    bit ok, mh;
    logic signed [31:0] mt;
    int mi;
    clear_tables();
    res_hit[2] = 1'b1; res_t[2] = 32'sh0002_0000;
    res_hit[5] = 1'b1; res_t[5] = 32'sh0002_0000;
    resp_delay = 2;
    feed_const = 0;
    feed_en    = 1;
    start_job(7);
    wait_done(200, ok);
    feed_en = 0;
    model(7, mh, mt, mi);
    n_cmp += 5;
    if (!ok) begin n_bad++; $display("FAIL tie_done_timeout got=0 want=1"); end
    if (hit !== mh) begin n_bad++; $display("FAIL tie_hit got=%b want=%b", hit, mh); end
    if (hit_t !== mt) begin n_bad++; $display("FAIL tie_t got=%h want=%h", hit_t, mt); end
    if (hit_idx !== IDX_W'(mi)) begin n_bad++; $display("FAIL tie_idx got=%0d want=%0d", hit_idx, mi); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL tie_err got=%b want=0", err); end
  endtask

  task automatic test_reset_mid();
    bit reached;
    int base;
    clear_tables();
    for (int i = 0; i < 10; i++) begin
      res_hit[i] = 1'b1;
      res_t[i]   = 32'sh0000_0100;
    end
    resp_delay = 6;
    feed_const = 1;
    feed_en    = 1;
    start_job(10);
    reached = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (model_infl >= 4) begin
        reached = 1;
        break;
      end
    end
    n_cmp++;
    if (!reached) begin n_bad++; $display("FAIL rmid_inflight_timeout got=%0d want=4", model_infl); end
    @(posedge clk);
    #1;
    rst     = 1'b1;
    feed_en = 0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = done_cnt;
    @(negedge clk);
    #2;
    n_cmp += 5;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    if (hit !== 1'b0) begin n_bad++; $display("FAIL rmid_hit got=%b want=0", hit); end
    if (hit_t !== 32'sh7FFF_FFFF) begin n_bad++; $display("FAIL rmid_hit_t got=%h want=7fffffff", hit_t); end
    if (tri_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_ready got=%b want=0", tri_ready); end
    if (err !== 1'b0) begin n_bad++; $display("FAIL rmid_err got=%b want=0", err); end
    repeat (15) @(negedge clk);
    #2;
    n_cmp += 3;
    if (err !== 1'b0) begin n_bad++; $display("FAIL rmid_late_err got=%b want=0", err); end
    if (hit !== 1'b0) begin n_bad++; $display("FAIL rmid_late_hit got=%b want=0", hit); end
    if (done_cnt != base) begin n_bad++; $display("FAIL rmid_done got=%0d want=%0d", done_cnt, base); end
  endtask

`ifdef SCHED_ANYHIT_EN
  task automatic test_anyhit();
    bit ok, mh;
    logic signed [31:0] mt;
    int mi;
    clear_tables();
    res_hit[0] = 1'b1; res_t[0] = 32'sh0005_0000;
    res_hit[3] = 1'b1; res_t[3] = 32'sh0001_0000;
    resp_delay = 4;
    feed_const = 1;
    feed_en    = 1;
    start_job(10);
    wait_done(200, ok);
    feed_en = 0;
    model(10, mh, mt, mi);
    n_cmp += 5;
    if (!ok) begin n_bad++; $display("FAIL any_done_timeout got=0 want=1"); end
    if (hit_idx !== IDX_W'(mi)) begin n_bad++; $display("FAIL any_idx got=%0d want=%0d", hit_idx, mi); end
    if (hit_t !== mt) begin n_bad++; $display("FAIL any_t got=%h want=%h", hit_t, mt); end
    if (ready_after_hit) begin n_bad++; $display("FAIL any_ready got=1 want=0"); end
    if (en_cnt >= 10) begin n_bad++; $display("FAIL any_issued got=%0d want=<10", en_cnt); end
  endtask
`endif

  initial begin
    clear_tables();
    test_reset();
    test_closest();
    test_zero();
    test_err();
    test_back_to_back();
    test_tie();
    test_reset_mid();
`ifdef SCHED_ANYHIT_EN
    test_anyhit();
`endif
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
